// File: rtl/alu_word_sequencer.sv
// alu_word_sequencer: runs a 4-bit ALU slice once per nibble (LSB first) to build a 4*NIBBLES-bit result.
//   clk_i, reset_n_i        : clock, synchronous active-low reset
//   start_i                 : operation request, sampled only when idle
//   op_a_i, op_b_i          : word operands, latched on accepted start
//   op_cin_i, op_sel_i      : carry into nibble 0 and slice select {s1,s0}, latched on accepted start
//   busy_o, done_o          : nibble passes in progress / one-cycle completion pulse
//   result_o, carry_o       : registered word result and carry-out of the top nibble
//   alu_a_o, alu_b_o        : current operand nibbles to the slice
//   alu_cin_o, alu_s1_o/s0_o: carry and latched select to the slice
//   alu_f_i, alu_cout_i     : slice function output and carry-out
module alu_word_sequencer #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk_i,
   input  logic                 reset_n_i,
   input  logic                 start_i,
   input  logic [4*NIBBLES-1:0] op_a_i,
   input  logic [4*NIBBLES-1:0] op_b_i,
   input  logic                 op_cin_i,
   input  logic [1:0]           op_sel_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [4*NIBBLES-1:0] result_o,
   output logic                 carry_o,
   output logic [3:0]           alu_a_o,
   output logic [3:0]           alu_b_o,
   output logic                 alu_cin_o,
   output logic                 alu_s1_o,
   output logic                 alu_s0_o,
   input  logic [3:0]           alu_f_i,
   input  logic                 alu_cout_i
);
   localparam int W  = 4*NIBBLES;
   localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t        state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [W-1:0]  a_q, a_d, b_q, b_d, result_q, result_d;
   logic [1:0]    sel_q, sel_d;
   logic          carry_q, carry_d, last;
   assign last = idx_q == IW'(NIBBLES-1);
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      a_d      = a_q;
      b_d      = b_q;
      sel_d    = sel_q;
      carry_d  = carry_q;
      result_d = result_q;
      if (state_q == IDLE && start_i) begin
         state_d = RUN;
         idx_d   = '0;
         a_d     = op_a_i;
         b_d     = op_b_i;
         sel_d   = op_sel_i;
         carry_d = op_cin_i;
      end else if (state_q == RUN) begin
         // the slice output is captured the same cycle it is driven; the carry chains into the next pass
         result_d[{idx_q, 2'b00} +: 4] = alu_f_i;
         carry_d = alu_cout_i;
         idx_d   = last ? '0 : idx_q + 1'b1;
         state_d = last ? DONE : RUN;
      end else if (state_q == DONE) begin
         state_d = IDLE;
      end
   end
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         sel_q    <= '0;
         carry_q  <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         a_q      <= a_d;
         b_q      <= b_d;
         sel_q    <= sel_d;
         carry_q  <= carry_d;
         result_q <= result_d;
      end
   end
   assign busy_o    = state_q == RUN;
   assign done_o    = state_q == DONE;
   assign result_o  = result_q;
   assign carry_o   = carry_q;
   assign alu_a_o   = busy_o ? a_q[{idx_q, 2'b00} +: 4] : 4'h0;
   assign alu_b_o   = busy_o ? b_q[{idx_q, 2'b00} +: 4] : 4'h0;
   assign alu_cin_o = busy_o & carry_q;
   assign alu_s1_o  = sel_q[1];
   assign alu_s0_o  = sel_q[0];
endmodule

// File: tb/tb_alu_word_sequencer.sv
// tb_alu_word_sequencer: randomized and directed checks of alu_word_sequencer against word-level arithmetic.
//   Attaches a behavioural 4-bit slice (00 add, 01 add-inverted-b, 10 and, 11 xor) to the sequencer.
module tb_alu_word_sequencer;
   logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0, op_cin = 1'b0;
   logic [15:0] op_a = '0, op_b = '0;
   logic [1:0]  op_sel = '0;
   logic        busy, done, carry, alu_cin, alu_s1, alu_s0, alu_cout;
   logic [15:0] result;
   logic [3:0]  alu_a, alu_b, alu_f;
   logic [4:0]  slice;
   int          n_vec = 0, n_err = 0;

   always #5 clk = ~clk;

   alu_word_sequencer #(.NIBBLES(4)) dut (
      .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .op_a_i(op_a), .op_b_i(op_b),
      .op_cin_i(op_cin), .op_sel_i(op_sel), .busy_o(busy), .done_o(done), .result_o(result),
      .carry_o(carry), .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_cin_o(alu_cin),
      .alu_s1_o(alu_s1), .alu_s0_o(alu_s0), .alu_f_i(alu_f), .alu_cout_i(alu_cout)
   );

   always_comb begin
      slice = {alu_s1, alu_s0} == 2'b00 ? {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin} :
              {alu_s1, alu_s0} == 2'b01 ? {1'b0, alu_a} + {1'b0, ~alu_b} + {4'b0, alu_cin} :
              {alu_s1, alu_s0} == 2'b10 ? {1'b0, alu_a & alu_b} : {1'b0, alu_a ^ alu_b};
   end
   assign alu_f    = slice[3:0];
   assign alu_cout = slice[4];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // word-level reference: {carry, result}
   function automatic logic [16:0] ref_word(input logic [15:0] a, input logic [15:0] b,
                                            input logic cin, input logic [1:0] sel);
      case (sel)
         2'b00:   return {1'b0, a} + {1'b0, b} + {16'b0, cin};
         2'b01:   return {1'b0, a} + {1'b0, ~b} + {16'b0, cin};
         2'b10:   return {1'b0, a & b};
         default: return {1'b0, a ^ b};
      endcase
   endfunction

   // carry entering nibble i, from the low 4*i bits of the arithmetic sum
   function automatic logic ref_cin(input logic [15:0] a, input logic [15:0] b,
                                    input logic cin, input logic [1:0] sel, input int i);
      int unsigned mask, bx;
      if (sel[1]) return i == 0 ? cin : 1'b0;
      mask = (32'd1 << (4*i)) - 1;
      bx   = sel[0] ? {16'b0, ~b} : {16'b0, b};
      return 1'(((a & mask) + (bx & mask) + cin) >> (4*i));
   endfunction

   task automatic check_run(input logic [15:0] a, input logic [15:0] b, input logic cin,
                            input logic [1:0] sel, input bit scramble);
      logic [16:0] r = ref_word(a, b, cin, sel);
      for (int i = 0; i < 4; i++) begin
         if (scramble) begin
            op_a = 16'($urandom);
            op_b = 16'($urandom);
            op_cin = 1'($urandom);
            op_sel = 2'($urandom);
         end
         check("busy_run", busy, 1);
         check("done_run", done, 0);
         check("alu_a", alu_a, a[4*i +: 4]);
         check("alu_b", alu_b, b[4*i +: 4]);
         check("alu_cin", alu_cin, ref_cin(a, b, cin, sel, i));
         check("alu_sel", {alu_s1, alu_s0}, sel);
         tick();
      end
      check("done_pulse", done, 1);
      check("busy_done", busy, 0);
      check("result", result, r[15:0]);
      check("carry", carry, r[16]);
      check("alu_a_done", alu_a, 0);
   endtask

   task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic [1:0] sel);
      op_a = a;
      op_b = b;
      op_cin = cin;
      op_sel = sel;
      start = 1'b1;
      tick();
      start = 1'b0;
      check_run(a, b, cin, sel, 1'b0);
      tick();
      check("done_width", done, 0);
      check("busy_idle", busy, 0);
      check("result_hold", result, ref_word(a, b, cin, sel) & 17'hFFFF);
   endtask

   initial begin
      logic [15:0] a, b;
      logic        c;
      logic [1:0]  s;
      int          dones;
      tick();
      tick();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_result", result, 0);
      check("rst_carry", carry, 0);
      check("rst_alu", {alu_a, alu_b, alu_cin, alu_s1, alu_s0}, 0);
      reset_n = 1'b1;
      tick();
      do_op(16'h1234, 16'h0FFF, 1'b0, 2'b00);
      check("dir_add", result, 16'h2233);
      do_op(16'hFFFF, 16'h0001, 1'b0, 2'b00);
      check("dir_ripple", {carry, result}, 17'h10000);
      do_op(16'h0005, 16'h0007, 1'b1, 2'b01);
      check("dir_sub_neg", {carry, result}, 17'h0FFFE);
      do_op(16'h0007, 16'h0005, 1'b1, 2'b01);
      check("dir_sub_pos", {carry, result}, 17'h10002);
      repeat (30) do_op(16'($urandom), 16'($urandom), 1'($urandom), 2'($urandom));
      // start held high: one accept per 6 cycles, operands changed outside acceptance are ignored
      a = 16'($urandom);
      b = 16'($urandom);
      c = 1'($urandom);
      s = 2'($urandom_range(0, 1));
      op_a = a;
      op_b = b;
      op_cin = c;
      op_sel = s;
      start = 1'b1;
      for (int j = 0; j < 4; j++) begin
         tick();
         check_run(a, b, c, s, 1'b1);
         tick();
         check("held_idle_busy", busy, 0);
         check("held_idle_done", done, 0);
         a = 16'($urandom);
         b = 16'($urandom);
         c = 1'($urandom);
         s = 2'($urandom);
         op_a = a;
         op_b = b;
         op_cin = c;
         op_sel = s;
      end
      start = 1'b0;
      tick();
      tick();
      // reset in the second RUN cycle aborts the operation
      op_a = 16'hABCD;
      op_b = 16'h1111;
      op_sel = 2'b00;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("abort_in_run", busy, 1);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_result", result, 0);
      check("abort_carry", carry, 0);
      check("abort_alu_a", alu_a, 0);
      dones = 0;
      repeat (8) begin
         tick();
         dones += int'(done) + int'(busy);
      end
      check("abort_no_done", dones, 0);
      do_op(16'h8000, 16'h8000, 1'b1, 2'b00);
      check("after_abort", {carry, result}, 17'h10001);
      // post-reset idle
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      dones = 0;
      repeat (20) begin
         tick();
         dones += int'(busy) + int'(done) + int'(result != 0) + int'(carry) +
                  int'({alu_a, alu_b, alu_cin, alu_s1, alu_s0} != 0);
      end
      check("idle_quiet", dones, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   always @(negedge clk) if (busy && done) begin
      n_vec++;
      n_err++;
      $display("FAIL busy_done_overlap: got 1 expected 0");
   end
endmodule
